// File: rtl/wb_core_router.sv
// Routes a single-outstanding Wishbone master transaction to one of two slaves
// by address, with a bounded wait for the slave ack and a saturating timeout count.
module wb_core_router #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] SPLIT_BASE     = 32'h0010_0000,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_cyc_i,
    input  logic                  m_stb_i,
    input  logic                  m_we_i,
    input  logic [ADDR_WIDTH-1:0] m_addr_i,
    input  logic [DATA_WIDTH-1:0] m_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_ack_o,
    output logic                  s0_cyc_o,
    output logic                  s0_stb_o,
    output logic                  s0_we_o,
    output logic [ADDR_WIDTH-1:0] s0_addr_o,
    output logic [DATA_WIDTH-1:0] s0_data_o,
    input  logic [DATA_WIDTH-1:0] s0_data_i,
    input  logic                  s0_ack_i,
    output logic                  s1_cyc_o,
    output logic                  s1_stb_o,
    output logic                  s1_we_o,
    output logic [ADDR_WIDTH-1:0] s1_addr_o,
    output logic [DATA_WIDTH-1:0] s1_data_o,
    input  logic [DATA_WIDTH-1:0] s1_data_i,
    input  logic                  s1_ack_i,
    output logic                  timeout_o,
    output logic [7:0]            err_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Counter value on the last permitted WAIT cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic                  r_sel;
    logic [15:0]           r_cnt;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_ack;
    logic                  r_s0_cyc, r_s0_we;
    logic [ADDR_WIDTH-1:0] r_s0_addr;
    logic [DATA_WIDTH-1:0] r_s0_data;
    logic                  r_s1_cyc, r_s1_we;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_timeout;
    logic [7:0]            r_err_count;

    logic                  w_ack;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Only the selected slave's ack and data are ever looked at.
    assign w_ack   = r_sel ? s1_ack_i : s0_ack_i;
    assign w_rdata = r_sel ? s1_data_i : s0_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            r_m_data    <= '0;
            r_m_ack     <= 1'b0;
            r_s0_cyc    <= 1'b0;
            r_s0_we     <= 1'b0;
            r_s0_addr   <= '0;
            r_s0_data   <= '0;
            r_s1_cyc    <= 1'b0;
            r_s1_we     <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_data   <= '0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_m_ack   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The master still holds stb while it sees our ack; skip that cycle.
                    if (m_cyc_i && m_stb_i && !r_m_ack) begin
                        r_cnt <= '0;
                        if (m_addr_i >= SPLIT_BASE) begin
                            r_sel     <= 1'b1;
                            r_s1_cyc  <= 1'b1;
                            r_s1_we   <= m_we_i;
                            r_s1_addr <= m_addr_i - SPLIT_BASE;
                            r_s1_data <= m_data_i;
                        end else begin
                            r_sel     <= 1'b0;
                            r_s0_cyc  <= 1'b1;
                            r_s0_we   <= m_we_i;
                            r_s0_addr <= m_addr_i;
                            r_s0_data <= m_data_i;
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!m_cyc_i) begin
                        r_s0_cyc <= 1'b0;
                        r_s0_we  <= 1'b0;
                        r_s1_cyc <= 1'b0;
                        r_s1_we  <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else if (w_ack) begin
                        r_m_data <= w_rdata;
                        r_s0_cyc <= 1'b0;
                        r_s0_we  <= 1'b0;
                        r_s1_cyc <= 1'b0;
                        r_s1_we  <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_m_data  <= ERR_DATA;
                        r_s0_cyc  <= 1'b0;
                        r_s0_we   <= 1'b0;
                        r_s1_cyc  <= 1'b0;
                        r_s1_we   <= 1'b0;
                        r_timeout <= 1'b1;
                        if (r_err_count != 8'hFF)
                            r_err_count <= r_err_count + 8'd1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    r_m_ack <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_data_o    = r_m_data;
    assign m_ack_o     = r_m_ack;
    assign s0_cyc_o    = r_s0_cyc;
    assign s0_stb_o    = r_s0_cyc;
    assign s0_we_o     = r_s0_we;
    assign s0_addr_o   = r_s0_addr;
    assign s0_data_o   = r_s0_data;
    assign s1_cyc_o    = r_s1_cyc;
    assign s1_stb_o    = r_s1_cyc;
    assign s1_we_o     = r_s1_we;
    assign s1_addr_o   = r_s1_addr;
    assign s1_data_o   = r_s1_data;
    assign timeout_o   = r_timeout;
    assign err_count_o = r_err_count;

endmodule

// File: tb/tb_wb_core_router.sv
// Directed bench for wb_core_router: routing, ack return, timeout, saturation,
// ack filtering, abort and reset, with hand-computed expectations.
module tb_wb_core_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc_i, m_stb_i, m_we_i;
    logic [31:0] m_addr_i, m_data_i, m_data_o;
    logic        m_ack_o;
    logic        s0_cyc_o, s0_stb_o, s0_we_o, s0_ack_i;
    logic [31:0] s0_addr_o, s0_data_o, s0_data_i;
    logic        s1_cyc_o, s1_stb_o, s1_we_o, s1_ack_i;
    logic [31:0] s1_addr_o, s1_data_o, s1_data_i;
    logic        timeout_o;
    logic [7:0]  err_count_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_core_router #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .SPLIT_BASE    (32'h0010_0000),
        .TIMEOUT_CYCLES(4),
        .ERR_DATA      (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_cyc_i    (m_cyc_i),
        .m_stb_i    (m_stb_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_data_i   (m_data_i),
        .m_data_o   (m_data_o),
        .m_ack_o    (m_ack_o),
        .s0_cyc_o   (s0_cyc_o),
        .s0_stb_o   (s0_stb_o),
        .s0_we_o    (s0_we_o),
        .s0_addr_o  (s0_addr_o),
        .s0_data_o  (s0_data_o),
        .s0_data_i  (s0_data_i),
        .s0_ack_i   (s0_ack_i),
        .s1_cyc_o   (s1_cyc_o),
        .s1_stb_o   (s1_stb_o),
        .s1_we_o    (s1_we_o),
        .s1_addr_o  (s1_addr_o),
        .s1_data_o  (s1_data_o),
        .s1_data_i  (s1_data_i),
        .s1_ack_i   (s1_ack_i),
        .timeout_o  (timeout_o),
        .err_count_o(err_count_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data);
        m_cyc_i  = 1'b1;
        m_stb_i  = 1'b1;
        m_we_i   = we;
        m_addr_i = addr;
        m_data_i = data;
    endtask

    task automatic release_master();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_addr_i = 0; m_data_i = 0;
        s0_ack_i = 0; s0_data_i = 0; s1_ack_i = 0; s1_data_i = 0;
        tick();
        tick();
        chk("rst_m_ack", 32'(m_ack_o), 32'd0);
        chk("rst_m_data", m_data_o, 32'h0);
        chk("rst_s0_cyc", 32'(s0_cyc_o), 32'd0);
        chk("rst_s1_cyc", 32'(s1_cyc_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_err", 32'(err_count_o), 32'd0);
        rst = 1'b0;

        // Read to s0 with an ack in its first stb cycle.
        req(1'b0, 32'h0000_0040, 32'h0);
        tick();
        chk("t1_s0_stb", 32'(s0_stb_o), 32'd1);
        chk("t1_s0_addr", s0_addr_o, 32'h0000_0040);
        chk("t1_s1_cyc", 32'(s1_cyc_o), 32'd0);
        s0_ack_i = 1'b1; s0_data_i = 32'h1234_5678;
        tick();
        chk("t1_s0_drop", 32'(s0_cyc_o), 32'd0);
        chk("t1_early_ack", 32'(m_ack_o), 32'd0);
        s0_ack_i = 1'b0;
        tick();
        chk("t1_m_ack", 32'(m_ack_o), 32'd1);
        chk("t1_m_data", m_data_o, 32'h1234_5678);
        tick();
        chk("t1_ack_len", 32'(m_ack_o), 32'd0);
        chk("t1_no_reaccept", 32'(s0_cyc_o), 32'd0);
        release_master();
        tick();
        $display("txn read  0x00000040 -> 0x%08h", m_data_o);

        // Write to s1, acked in its third stb cycle.
        req(1'b1, 32'h0010_0008, 32'hCAFE_F00D);
        tick();
        chk("t2_s1_stb", 32'(s1_stb_o), 32'd1);
        chk("t2_s1_we", 32'(s1_we_o), 32'd1);
        chk("t2_s1_addr", s1_addr_o, 32'h0000_0008);
        chk("t2_s1_data", s1_data_o, 32'hCAFE_F00D);
        chk("t2_s0_cyc", 32'(s0_cyc_o), 32'd0);
        chk("t2_s0_addr_hold", s0_addr_o, 32'h0000_0040);
        tick();
        tick();
        chk("t2_s1_stable", 32'(s1_stb_o), 32'd1);
        chk("t2_no_ack_yet", 32'(m_ack_o), 32'd0);
        s1_ack_i = 1'b1; s1_data_i = 32'h5555_AAAA;
        tick();
        chk("t2_s1_drop", 32'(s1_cyc_o), 32'd0);
        s1_ack_i = 1'b0;
        tick();
        chk("t2_m_ack", 32'(m_ack_o), 32'd1);
        chk("t2_m_data", m_data_o, 32'h5555_AAAA);
        release_master();
        tick();
        chk("t2_ack_len", 32'(m_ack_o), 32'd0);
        $display("txn write 0x00100008 acked, data 0x%08h", m_data_o);

        // Timeout on s1, then a late ack that must be ignored.
        req(1'b0, 32'h0020_0000, 32'h0);
        tick();
        chk("t3_s1_addr", s1_addr_o, 32'h0010_0000);
        tick(); tick(); tick();
        chk("t3_s1_still", 32'(s1_stb_o), 32'd1);
        chk("t3_no_to_yet", 32'(timeout_o), 32'd0);
        tick();
        chk("t3_s1_drop", 32'(s1_stb_o), 32'd0);
        chk("t3_timeout", 32'(timeout_o), 32'd1);
        chk("t3_err_data", m_data_o, 32'hDEAD_BEEF);
        chk("t3_err_cnt", 32'(err_count_o), 32'd1);
        tick();
        chk("t3_to_pulse", 32'(timeout_o), 32'd0);
        chk("t3_m_ack", 32'(m_ack_o), 32'd1);
        release_master();
        s1_ack_i = 1'b1;
        tick();
        chk("t3_late1", 32'(m_ack_o), 32'd0);
        tick();
        chk("t3_late2", 32'(m_ack_o), 32'd0);
        s1_ack_i = 1'b0;
        $display("txn read  0x00200000 timed out, err_count %0d", err_count_o);

        // s0 ack on the last permitted cycle, with a spurious s1 ack earlier.
        req(1'b0, 32'h0000_0100, 32'h0);
        tick();
        s1_ack_i = 1'b1; s1_data_i = 32'h1111_1111;
        tick();
        chk("t4_spurious", 32'(s0_stb_o), 32'd1);
        s1_ack_i = 1'b0;
        tick();
        tick();
        s0_ack_i = 1'b1; s0_data_i = 32'h0BAD_CAFE;
        tick();
        chk("t4_no_timeout", 32'(timeout_o), 32'd0);
        chk("t4_s0_drop", 32'(s0_cyc_o), 32'd0);
        chk("t4_err_cnt", 32'(err_count_o), 32'd1);
        s0_ack_i = 1'b0;
        tick();
        chk("t4_m_ack", 32'(m_ack_o), 32'd1);
        chk("t4_m_data", m_data_o, 32'h0BAD_CAFE);
        release_master();
        tick();
        $display("txn read  0x00000100 boundary ack -> 0x%08h", m_data_o);

        // Master abort mid-WAIT, then a normal request.
        req(1'b0, 32'h0000_0080, 32'h0);
        tick();
        tick();
        release_master();
        tick();
        chk("t5_abort_drop", 32'(s0_cyc_o), 32'd0);
        chk("t5_abort_ack", 32'(m_ack_o), 32'd0);
        tick();
        chk("t5_abort_ack2", 32'(m_ack_o), 32'd0);
        req(1'b0, 32'h0000_0044, 32'h0);
        tick();
        chk("t5_new_addr", s0_addr_o, 32'h0000_0044);
        s0_ack_i = 1'b1; s0_data_i = 32'h7777_0044;
        tick();
        s0_ack_i = 1'b0;
        tick();
        chk("t5_new_ack", 32'(m_ack_o), 32'd1);
        chk("t5_new_data", m_data_o, 32'h7777_0044);
        release_master();
        tick();
        $display("txn abort then read 0x00000044 -> 0x%08h", m_data_o);

        // Back-to-back timeouts drive the error counter into saturation.
        for (int i = 0; i < 300; i++) begin
            req(1'b0, 32'h0030_0000, 32'h0);
            tick();
            tick(); tick(); tick(); tick();
            tick();
            chk("t6_m_ack", 32'(m_ack_o), 32'd1);
            chk("t6_err_cnt", 32'(err_count_o), (i < 253) ? 32'(i + 2) : 32'd255);
            release_master();
            tick();
            $display("txn timeout %0d, err_count %0d", i, err_count_o);
        end

        // Reset in the middle of a write to s1.
        req(1'b1, 32'h0010_0010, 32'hA5A5_5A5A);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t7_s1_cyc", 32'(s1_cyc_o), 32'd0);
        chk("t7_s1_addr", s1_addr_o, 32'h0);
        chk("t7_s1_data", s1_data_o, 32'h0);
        chk("t7_s0_addr", s0_addr_o, 32'h0);
        chk("t7_m_data", m_data_o, 32'h0);
        chk("t7_err_cnt", 32'(err_count_o), 32'd0);
        chk("t7_m_ack", 32'(m_ack_o), 32'd0);
        rst = 1'b0;
        release_master();
        tick();
        chk("t7_m_ack_after", 32'(m_ack_o), 32'd0);
        $display("txn write 0x00100010 cut by reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
